// File: rtl/assoc_cache_bank_pkg.sv
// Shared definitions for the associative cache bank family.
//   repl_mode_e       : replacement policy selector (LFSR pseudo-random or round-robin)
//   LFSR_SEED_DEFAULT : default nonzero reset seed for the 16-bit victim LFSR
//   cache_line_t      : one cache line (tag + payload) at the default bank geometry
package assoc_cache_bank_pkg;

  typedef enum logic [0:0] {
    REPL_LFSR = 1'b0,
    REPL_RR   = 1'b1
  } repl_mode_e;

  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  localparam int DEF_TAG_BITS  = 28;
  localparam int DEF_DATA_BITS = 64;

  typedef struct packed {
    logic [DEF_TAG_BITS-1:0]  tag;
    logic [DEF_DATA_BITS-1:0] data;
  } cache_line_t;

endpackage

// File: rtl/assoc_cache_bank_lfsr16.sv
// Free-running 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11).
// Ports:
//   clock, reset : system clock, synchronous active-high reset (loads seed_i)
//   seed_i       : reset value, must be nonzero
//   lfsr_o       : current LFSR state, advances every cycle
module lfsr16 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= seed_i;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/assoc_cache_bank.sv
// Fully associative cache bank: READ_PORTS combinational lookup ports, one
// fill port with valid/ready, a tag-invalidate port and a one-entry eviction
// register drained over valid/ready.
// Ports:
//   clock, reset             : system clock, synchronous active-high reset
//   rd_tag_i/rd_hit_o/rd_data_o : per-port lookup (flattened, port 0 in LSBs);
//                              data is 0 on a miss, fills forward same cycle
//   wr_valid_i/wr_ready_o, wr_tag_i, wr_data_i : fill request
//   inv_valid_i, inv_tag_i   : invalidate request, effective next cycle
//   evict_valid_o/evict_ready_i, evict_tag_o, evict_data_o : displaced victim
//   occupancy_o              : number of valid lines
module assoc_cache_bank
  import assoc_cache_bank_pkg::*;
#(
  parameter int          LINES      = 16,
  parameter int          READ_PORTS = 2,
  parameter int          TAG_BITS   = 28,
  parameter int          DATA_BITS  = 64,
  parameter repl_mode_e  REPL_MODE  = REPL_LFSR,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [READ_PORTS*TAG_BITS-1:0]  rd_tag_i,
  output logic [READ_PORTS-1:0]           rd_hit_o,
  output logic [READ_PORTS*DATA_BITS-1:0] rd_data_o,
  input  logic                            wr_valid_i,
  output logic                            wr_ready_o,
  input  logic [TAG_BITS-1:0]             wr_tag_i,
  input  logic [DATA_BITS-1:0]            wr_data_i,
  input  logic                            inv_valid_i,
  input  logic [TAG_BITS-1:0]             inv_tag_i,
  output logic                            evict_valid_o,
  input  logic                            evict_ready_i,
  output logic [TAG_BITS-1:0]             evict_tag_o,
  output logic [DATA_BITS-1:0]            evict_data_o,
  output logic [$clog2(LINES+1)-1:0]      occupancy_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OCC_W = $clog2(LINES+1);

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [DATA_BITS-1:0] data_q [LINES];

  logic                 evict_valid_q, evict_valid_d;
  logic [TAG_BITS-1:0]  evict_tag_q,   evict_tag_d;
  logic [DATA_BITS-1:0] evict_data_q,  evict_data_d;
  logic [OCC_W-1:0]     occupancy_q,   occupancy_d;

  logic             wr_hit, has_free, inv_hit;
  logic [IDX_W-1:0] wr_hit_idx, free_idx, inv_idx, victim_idx, wr_idx;
  logic             full_miss, needs_evict, wr_fire, evict_load, inv_eff;

  // Tag match for fill and invalidate, plus lowest-index free line.
  // Descending scan so the lowest matching index is the one kept.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    has_free   = 1'b0;
    free_idx   = '0;
    inv_hit    = 1'b0;
    inv_idx    = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == wr_tag_i) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == inv_tag_i) begin
        inv_hit = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
  end

  generate
    if (REPL_MODE == REPL_LFSR) begin : g_lfsr
      logic [15:0]      lfsr;
      logic [15-IDX_W:0] lfsr_hi_unused;

      lfsr16 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .seed_i (LFSR_SEED),
        .lfsr_o (lfsr)
      );

      assign victim_idx     = lfsr[IDX_W-1:0];
      assign lfsr_hi_unused = lfsr[15:IDX_W];
    end else begin : g_rr
      logic [IDX_W-1:0] rr_q, rr_d;

      // Pointer moves only when a victim is actually displaced.
      assign rr_d = evict_load ? rr_q + IDX_W'(1) : rr_q;

      always_ff @(posedge clock) begin
        if (reset) rr_q <= '0;
        else       rr_q <= rr_d;
      end

      assign victim_idx = rr_q;
    end
  endgenerate

  assign full_miss   = !wr_hit && !has_free;
  assign needs_evict = wr_valid_i && full_miss;
  // A victim can only be taken if the eviction register is empty or draining.
  assign wr_ready_o  = !needs_evict || !evict_valid_q || evict_ready_i;
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign evict_load  = wr_fire && full_miss;
  assign wr_idx      = wr_hit ? wr_hit_idx : (has_free ? free_idx : victim_idx);

  // A same-cycle fill to the invalidated line wins. This covers both the
  // same-tag case (in-place overwrite) and the case where the invalidated
  // line is the one being replaced by a victim fill.
  assign inv_eff = inv_valid_i && inv_hit && !(wr_fire && inv_idx == wr_idx);

  always_comb begin
    occupancy_d = occupancy_q;
    if (wr_fire && !wr_hit && has_free) occupancy_d = occupancy_d + OCC_W'(1);
    if (inv_eff)                        occupancy_d = occupancy_d - OCC_W'(1);
  end

  // Victim captured from pre-write contents; a new victim beats a drain.
  always_comb begin
    evict_valid_d = evict_valid_q;
    evict_tag_d   = evict_tag_q;
    evict_data_d  = evict_data_q;
    if (evict_load) begin
      evict_valid_d = 1'b1;
      evict_tag_d   = tag_q[victim_idx];
      evict_data_d  = data_q[victim_idx];
    end else if (evict_ready_i) begin
      evict_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q       <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      evict_data_q  <= '0;
      occupancy_q   <= '0;
    end else begin
      if (inv_eff) valid_q[inv_idx] <= 1'b0;
      if (wr_fire) valid_q[wr_idx]  <= 1'b1;
      evict_valid_q <= evict_valid_d;
      evict_tag_q   <= evict_tag_d;
      evict_data_q  <= evict_data_d;
      occupancy_q   <= occupancy_d;
    end
  end

  // Line payload is gated by valid_q, so it needs no reset.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      tag_q[wr_idx]  <= wr_tag_i;
      data_q[wr_idx] <= wr_data_i;
    end
  end

  // Lookup: OR-reduce matching lines, then let an accepted same-tag fill
  // override (also replaces the stale data of an in-place overwrite).
  always_comb begin
    rd_hit_o  = '0;
    rd_data_o = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      for (int i = 0; i < LINES; i++) begin
        if (valid_q[i] && tag_q[i] == rd_tag_i[p*TAG_BITS +: TAG_BITS]) begin
          rd_hit_o[p] = 1'b1;
          rd_data_o[p*DATA_BITS +: DATA_BITS] = rd_data_o[p*DATA_BITS +: DATA_BITS] | data_q[i];
        end
      end
      if (wr_fire && wr_tag_i == rd_tag_i[p*TAG_BITS +: TAG_BITS]) begin
        rd_hit_o[p] = 1'b1;
        rd_data_o[p*DATA_BITS +: DATA_BITS] = wr_data_i;
      end
    end
  end

  assign evict_valid_o = evict_valid_q;
  assign evict_tag_o   = evict_tag_q;
  assign evict_data_o  = evict_data_q;
  assign occupancy_o   = occupancy_q;

  // Tags must stay unique among valid lines.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < LINES; i++)
        for (int j = i + 1; j < LINES; j++)
          assert (!(valid_q[i] && valid_q[j] && tag_q[i] == tag_q[j]));
    end
  end

endmodule

// File: tb/tb_assoc_cache_bank.sv
// Testbench for assoc_cache_bank: a round-robin instance carries the main
// scenarios; an LFSR instance sharing the same stimulus is checked for
// victim selection against a reference LFSR after reset.
module tb_assoc_cache_bank;
  import assoc_cache_bank_pkg::*;

  logic          clock, reset;
  logic [55:0]   rd_tag;
  logic [1:0]    rd_hit;
  logic [127:0]  rd_data;
  logic          wr_valid, wr_ready;
  logic [27:0]   wr_tag;
  logic [63:0]   wr_data;
  logic          inv_valid;
  logic [27:0]   inv_tag;
  logic          evict_valid, evict_ready;
  logic [27:0]   evict_tag;
  logic [63:0]   evict_data;
  logic [4:0]    occupancy;

  logic [1:0]    lfsr_rd_hit_unused;
  logic [127:0]  lfsr_rd_data_unused;
  logic          wr_ready_l, evict_valid_l, evict_ready_l;
  logic [27:0]   evict_tag_l;
  logic [63:0]   evict_data_l;
  logic [4:0]    occupancy_l;

  int checks = 0;
  int errors = 0;
  logic [91:0] exp_q[$];
  logic [91:0] exp_e;
  logic [15:0] m_lfsr;

  assoc_cache_bank #(.LINES(16), .READ_PORTS(2), .TAG_BITS(28), .DATA_BITS(64),
                     .REPL_MODE(REPL_RR), .LFSR_SEED(16'hACE1)) dut (
    .clock(clock), .reset(reset),
    .rd_tag_i(rd_tag), .rd_hit_o(rd_hit), .rd_data_o(rd_data),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_tag_i(wr_tag), .wr_data_i(wr_data),
    .inv_valid_i(inv_valid), .inv_tag_i(inv_tag),
    .evict_valid_o(evict_valid), .evict_ready_i(evict_ready),
    .evict_tag_o(evict_tag), .evict_data_o(evict_data), .occupancy_o(occupancy)
  );

  assoc_cache_bank #(.LINES(16), .READ_PORTS(2), .TAG_BITS(28), .DATA_BITS(64),
                     .REPL_MODE(REPL_LFSR), .LFSR_SEED(16'hACE1)) dut_lfsr (
    .clock(clock), .reset(reset),
    .rd_tag_i(rd_tag), .rd_hit_o(lfsr_rd_hit_unused), .rd_data_o(lfsr_rd_data_unused),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_l), .wr_tag_i(wr_tag), .wr_data_i(wr_data),
    .inv_valid_i(inv_valid), .inv_tag_i(inv_tag),
    .evict_valid_o(evict_valid_l), .evict_ready_i(evict_ready_l),
    .evict_tag_o(evict_tag_l), .evict_data_o(evict_data_l), .occupancy_o(occupancy_l)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clock) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_base;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_tag = 28'(16 + i); wr_data = 64'((16 + i) * 3);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_valid = 1'b0; inv_valid = 1'b0; evict_ready = 1'b0; evict_ready_l = 1'b1;
    rd_tag = '0; wr_tag = '0; wr_data = '0; inv_tag = '0;
    tick(); tick();
    reset = 1'b0; #1;
    checks++; if (evict_valid !== 1'b0) begin errors++; $display("FAIL reset_evict_valid got %b want 0", evict_valid); end
    checks++; if (evict_tag !== 28'h0 || evict_data !== 64'h0) begin errors++; $display("FAIL reset_evict_reg got %h/%h want 0/0", evict_tag, evict_data); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    checks++; if (rd_hit !== 2'b00) begin errors++; $display("FAIL reset_rd_hit got %b want 00", rd_hit); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
  endtask

  task automatic test_forward;
    wr_valid = 1'b1; wr_tag = 28'h55; wr_data = 64'hBEEF;
    rd_tag = {28'h55, 28'h10}; #1;
    checks++; if (rd_hit !== 2'b10) begin errors++; $display("FAIL fwd_hit got %b want 10", rd_hit); end
    checks++; if (rd_data[127:64] !== 64'hBEEF || rd_data[63:0] !== 64'h0) begin errors++; $display("FAIL fwd_data got %h want 000000000000beef0000000000000000", rd_data); end
    tick();
    wr_valid = 1'b0; #1;
    checks++; if (rd_hit !== 2'b10 || rd_data[127:64] !== 64'hBEEF) begin errors++; $display("FAIL fwd_stored got %b/%h want 10/beef", rd_hit, rd_data[127:64]); end
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL fwd_occupancy got %0d want 1", occupancy); end
  endtask

  task automatic test_fill_hit;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_tag = 28'(16 + i); wr_data = 64'((16 + i) * 3); #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL fill_wr_ready[%0d] got %b want 1", i, wr_ready); end
      tick();
    end
    wr_valid = 1'b0; rd_tag = {28'h20, 28'h13}; #1;
    checks++; if (occupancy !== 5'd16 || occupancy_l !== 5'd16) begin errors++; $display("FAIL fill_occupancy got %0d/%0d want 16/16", occupancy, occupancy_l); end
    checks++; if (evict_valid !== 1'b0) begin errors++; $display("FAIL fill_no_evict got %b want 0", evict_valid); end
    checks++; if (rd_hit !== 2'b01) begin errors++; $display("FAIL fill_rd_hit got %b want 01", rd_hit); end
    checks++; if (rd_data[63:0] !== 64'h39 || rd_data[127:64] !== 64'h0) begin errors++; $display("FAIL fill_rd_data got %h/%h want 39/0", rd_data[63:0], rd_data[127:64]); end
  endtask

  task automatic test_rr_evict;
    wr_valid = 1'b1; wr_tag = 28'h40; wr_data = 64'hC0; evict_ready = 1'b0; #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rr_first_ready got %b want 1", wr_ready); end
    exp_q.push_back({28'h10, 64'h30});
    tick();
    wr_tag = 28'h41; wr_data = 64'hC3; #1;
    checks++; if (evict_valid !== 1'b1) begin errors++; $display("FAIL rr_evict_valid got %b want 1", evict_valid); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rr_backpressure[%0d] got %b want 0", k, wr_ready); end
      checks++; if (evict_tag !== 28'h10) begin errors++; $display("FAIL rr_hold_tag[%0d] got %h want 10", k, evict_tag); end
      tick();
    end
    evict_ready = 1'b1; #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rr_release_ready got %b want 1", wr_ready); end
    exp_e = exp_q.pop_front();
    checks++; if ({evict_tag, evict_data} !== exp_e) begin errors++; $display("FAIL rr_victim0 got %h/%h want %h/%h", evict_tag, evict_data, exp_e[91:64], exp_e[63:0]); end
    exp_q.push_back({28'h11, 64'h33});
    tick();
    wr_valid = 1'b0; evict_ready = 1'b0; #1;
    checks++; if (evict_valid !== 1'b1) begin errors++; $display("FAIL rr_second_valid got %b want 1", evict_valid); end
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL rr_occupancy got %0d want 16", occupancy); end
  endtask

  task automatic test_overwrite;
    wr_valid = 1'b1; wr_tag = 28'h13; wr_data = 64'hAAAA; #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ovw_wr_ready got %b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0; rd_tag = {28'h0, 28'h13}; #1;
    checks++; if (rd_hit[0] !== 1'b1 || rd_data[63:0] !== 64'hAAAA) begin errors++; $display("FAIL ovw_read got %b/%h want 1/aaaa", rd_hit[0], rd_data[63:0]); end
    checks++; if (evict_valid !== 1'b1 || evict_tag !== 28'h11 || occupancy !== 5'd16) begin errors++; $display("FAIL ovw_no_evict got %b/%h/%0d want 1/11/16", evict_valid, evict_tag, occupancy); end
    evict_ready = 1'b1; #1;
    exp_e = exp_q.pop_front();
    checks++; if ({evict_tag, evict_data} !== exp_e) begin errors++; $display("FAIL ovw_victim1 got %h/%h want %h/%h", evict_tag, evict_data, exp_e[91:64], exp_e[63:0]); end
    tick();
    evict_ready = 1'b0; #1;
    checks++; if (evict_valid !== 1'b0) begin errors++; $display("FAIL ovw_drained got %b want 0", evict_valid); end
  endtask

  task automatic test_invalidate;
    inv_valid = 1'b1; inv_tag = 28'h15; rd_tag = {28'h0, 28'h15}; #1;
    checks++; if (rd_hit[0] !== 1'b1 || rd_data[63:0] !== 64'h3F) begin errors++; $display("FAIL inv_same_cycle got %b/%h want 1/3f", rd_hit[0], rd_data[63:0]); end
    tick();
    inv_valid = 1'b0; #1;
    checks++; if (rd_hit[0] !== 1'b0) begin errors++; $display("FAIL inv_next_miss got %b want 0", rd_hit[0]); end
    checks++; if (occupancy !== 5'd15) begin errors++; $display("FAIL inv_occupancy got %0d want 15", occupancy); end
    wr_valid = 1'b1; wr_tag = 28'h60; wr_data = 64'h120; #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL inv_refill_ready got %b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0; rd_tag = {28'h0, 28'h60}; #1;
    checks++; if (evict_valid !== 1'b0 || occupancy !== 5'd16 || rd_hit[0] !== 1'b1) begin errors++; $display("FAIL inv_refill got %b/%0d/%b want 0/16/1", evict_valid, occupancy, rd_hit[0]); end
    inv_valid = 1'b1; inv_tag = 28'h60; wr_valid = 1'b1; wr_tag = 28'h60; wr_data = 64'h777;
    tick();
    inv_valid = 1'b0; wr_valid = 1'b0; #1;
    checks++; if (rd_hit[0] !== 1'b1 || rd_data[63:0] !== 64'h777 || occupancy !== 5'd16) begin errors++; $display("FAIL inv_fill_wins got %b/%h/%0d want 1/777/16", rd_hit[0], rd_data[63:0], occupancy); end
    inv_valid = 1'b1; inv_tag = 28'h99;
    tick();
    inv_valid = 1'b0; #1;
    checks++; if (occupancy !== 5'd16 || evict_valid !== 1'b0) begin errors++; $display("FAIL inv_nomatch got %0d/%b want 16/0", occupancy, evict_valid); end
  endtask

  task automatic test_reset_mid;
    wr_valid = 1'b1; wr_tag = 28'h70; wr_data = 64'h150; evict_ready = 1'b0;
    tick();
    wr_valid = 1'b0; #1;
    checks++; if (evict_valid !== 1'b1 || evict_tag !== 28'h12) begin errors++; $display("FAIL mid_pending got %b/%h want 1/12", evict_valid, evict_tag); end
    reset = 1'b1;
    tick();
    reset = 1'b0; rd_tag = {28'h70, 28'h10}; #1;
    checks++; if (evict_valid !== 1'b0 || evict_tag !== 28'h0) begin errors++; $display("FAIL mid_evict_cleared got %b/%h want 0/0", evict_valid, evict_tag); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL mid_occupancy got %0d want 0", occupancy); end
    checks++; if (rd_hit !== 2'b00) begin errors++; $display("FAIL mid_rd_hit got %b want 00", rd_hit); end
  endtask

  task automatic test_lfsr;
    logic [3:0] idx;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      evict_ready = 1'b1;
      fill_base();
      wr_valid = 1'b1; wr_tag = 28'h80; wr_data = 64'h180; #1;
      idx = m_lfsr[3:0];
      exp_q.push_back({28'(16 + idx), 64'((16 + idx) * 3)});
      checks++; if (wr_ready_l !== 1'b1) begin errors++; $display("FAIL lfsr_ready[%0d] got %b want 1", run, wr_ready_l); end
      tick();
      wr_valid = 1'b0; #1;
      exp_e = exp_q.pop_front();
      checks++; if (evict_valid_l !== 1'b1 || {evict_tag_l, evict_data_l} !== exp_e) begin errors++; $display("FAIL lfsr_victim[%0d] got %b/%h/%h want 1/%h/%h", run, evict_valid_l, evict_tag_l, evict_data_l, exp_e[91:64], exp_e[63:0]); end
      checks++; if (occupancy_l !== 5'd16) begin errors++; $display("FAIL lfsr_occupancy[%0d] got %0d want 16", run, occupancy_l); end
    end
    evict_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_fill_hit();
    test_rr_evict();
    test_overwrite();
    test_invalidate();
    test_reset_mid();
    test_lfsr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
